// File: rtl/mem_responder_if.sv
// Request/response handshake bundle for mem_responder.
// master = initiator (pipeline side), slave = memory target.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency single-port 16-bit memory target with valid/ready request and response.
// Optional MEM_BACK2BACK_EN: accept a new request on the same edge a response is consumed.
module mem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus,
    output logic            busy
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_responder: LATENCY must be in 1..15");
    end
    if (ADDR_W < 1 || ADDR_W > 14) begin : g_bad_addr_w
        $error("mem_responder: ADDR_W must be in 1..14");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [15:0]         rdata_q, rdata_d;

    logic [15:0]         mem [DEPTH];

    logic                req_ready_int;
    logic                accept;
    logic                commit;
    logic                commit_we;
    logic [ADDR_W-1:0]   commit_idx;
    logic [15:0]         commit_wdata;
    logic                mem_we;
    logic [ADDR_W-1:0]   req_idx;
    logic                unused_addr_bits;

    // Byte address: bit 0 and bits above the word index are dropped.
    assign req_idx          = bus.req_addr[ADDR_W:1];
    assign unused_addr_bits = ^{bus.req_addr[15:ADDR_W+1], bus.req_addr[0]};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        idx_d         = idx_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        req_ready_int = 1'b0;
        commit        = 1'b0;
        commit_we     = we_q;
        commit_idx    = idx_q;
        commit_wdata  = wdata_q;

        unique case (state_q)
            S_IDLE: req_ready_int = 1'b1;
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                    commit  = 1'b1;
                end
            end
            S_DONE: begin
`ifdef MEM_BACK2BACK_EN
                req_ready_int = bus.resp_ready;
`endif
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        accept = bus.req_valid && req_ready_int;
        if (accept) begin
            we_d    = bus.req_we;
            idx_d   = req_idx;
            wdata_d = bus.req_wdata;
            cnt_d   = CNT_INIT;
            if (LATENCY == 1) begin
                // Single-cycle latency: the access happens on the accept edge itself.
                state_d      = S_DONE;
                commit       = 1'b1;
                commit_we    = bus.req_we;
                commit_idx   = req_idx;
                commit_wdata = bus.req_wdata;
            end else begin
                state_d = S_WAIT;
            end
        end

        if (commit) rdata_d = commit_we ? commit_wdata : mem[commit_idx];
        mem_we = commit && commit_we && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is deliberately not reset; writes are blocked while rst is high.
    always_ff @(posedge clk) begin
        if (mem_we) mem[commit_idx] <= commit_wdata;
    end

    assign bus.req_ready  = req_ready_int;
    assign bus.resp_valid = (state_q == S_DONE);
    assign bus.resp_rdata = rdata_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder: a LATENCY=4 instance and a
// LATENCY=1 instance checked against a word-array reference model.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst;
    logic busy4, busy1;

    always #5 clk = ~clk;

    mem_responder_if bus4();
    mem_responder_if bus1();

    mem_responder #(.ADDR_W(10), .LATENCY(4)) u_dut4 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus4),
        .busy (busy4)
    );

    mem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus1),
        .busy (busy1)
    );

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    logic [15:0] model4 [1024];
    bit          known4 [1024];
    logic [15:0] model1 [1024];
    bit          known1 [1024];
    logic [15:0] exp_q1 [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned widx(input logic [15:0] a);
        return (32'(a) / 2) % 1024;
    endfunction

    // Entered and left on a negedge with the LATENCY=4 instance idle.
    task automatic txn4(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                        input int unsigned hold, input bit poke, output logic [15:0] got);
        int unsigned cyc;
        int unsigned idx;
        logic [15:0] held;
        idx = widx(addr);
        chk("idle_ready", bus4.req_ready, 1);
        bus4.req_valid  = 1'b1;
        bus4.req_we     = we;
        bus4.req_addr   = addr;
        bus4.req_wdata  = wdata;
        bus4.resp_ready = 1'b0;
        @(negedge clk);
        bus4.req_valid = 1'b0;
        cyc = 0;
        // resp_ready toggles while resp_valid is low and must have no effect.
        while (bus4.resp_valid !== 1'b1 && cyc < 20) begin
            bus4.resp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        bus4.resp_ready = 1'b0;
        // Seen on the negedge after edge T+3, i.e. high when sampled at edge T+4.
        chk("latency", cyc, 3);
        held = bus4.resp_rdata;
        got  = held;
        if (we) chk("store_rdata", held, wdata);
        else if (known4[idx]) chk("load_rdata", held, model4[idx]);
        if (we) begin
            model4[idx] = wdata;
            known4[idx] = 1'b1;
        end
        if (poke) begin
            bus4.req_valid = 1'b1;
            bus4.req_we    = 1'b1;
            bus4.req_addr  = 16'h0040;
            bus4.req_wdata = 16'hDEAD;
        end
        repeat (hold) begin
            @(negedge clk);
            chk("bp_valid", bus4.resp_valid, 1);
            chk("bp_rdata", bus4.resp_rdata, held);
            chk("bp_req_ready", bus4.req_ready, 0);
        end
        bus4.req_valid  = 1'b0;
        bus4.resp_ready = 1'b1;
        @(negedge clk);
        bus4.resp_ready = 1'b0;
        chk("resp_cleared", bus4.resp_valid, 0);
        chk("busy_cleared", busy4, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] got;
        int unsigned acc;
        int unsigned idx;
        bit          will_acc;
        bit          we;
        logic [15:0] wd;

        bus4.req_valid = 1'b0; bus4.req_we = 1'b0; bus4.req_addr = '0;
        bus4.req_wdata = '0;   bus4.resp_ready = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
        bus1.req_wdata = '0;   bus1.resp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus4.req_ready, 1);
        chk("rst_resp_valid", bus4.resp_valid, 0);
        chk("rst_rdata", bus4.resp_rdata, 0);
        chk("rst_busy", busy4, 0);
        chk("rst1_req_ready", bus1.req_ready, 1);
        chk("rst1_busy", busy1, 0);
        rst = 1'b0;
        @(negedge clk);

        txn4(1'b1, 16'h0020, 16'hBEEF, 0, 1'b0, got);
        txn4(1'b0, 16'h0020, 16'h0000, 0, 1'b0, got);
        chk("store_then_load", got, 16'hBEEF);

        txn4(1'b1, 16'hFFFF, 16'h1234, 0, 1'b0, got);
        txn4(1'b0, 16'h07FE, 16'h0000, 0, 1'b0, got);
        chk("wrap_align", got, 16'h1234);

        txn4(1'b1, 16'h0040, 16'h4040, 0, 1'b0, got);
        txn4(1'b0, 16'h0040, 16'h0000, 6, 1'b1, got);
        txn4(1'b0, 16'h0040, 16'h0000, 0, 1'b0, got);
        chk("poke_ignored", got, 16'h4040);

        // Store in flight when rst hits must never reach the array.
        txn4(1'b1, 16'h0010, 16'h1111, 0, 1'b0, got);
        bus4.req_valid = 1'b1; bus4.req_we = 1'b1;
        bus4.req_addr  = 16'h0010; bus4.req_wdata = 16'h2222;
        @(negedge clk);
        bus4.req_valid = 1'b0;
        @(negedge clk);
        chk("mid_wait_busy", busy4, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_req_ready", bus4.req_ready, 1);
        chk("arst_resp_valid", bus4.resp_valid, 0);
        chk("arst_rdata", bus4.resp_rdata, 0);
        chk("arst_busy", busy4, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        txn4(1'b0, 16'h0010, 16'h0000, 0, 1'b0, got);
        chk("dropped_store", got, 16'h1111);

        repeat (30) begin
            logic [15:0] a;
            we = 1'($urandom_range(0, 1));
            a  = 16'(($urandom_range(0, 31) << 11) | ($urandom_range(0, 15) << 1) | $urandom_range(0, 1));
            txn4(we, a, 16'($urandom), $urandom_range(0, 3), 1'b0, got);
        end

        // LATENCY=1 instance: continuous requests, consumer always ready.
        acc = 0;
        bus1.resp_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            idx = (c % 20) / 2;
            we  = (c < 20);
            wd  = 16'hA000 + 16'(c);
            bus1.req_valid = 1'b1;
            bus1.req_we    = we;
            bus1.req_addr  = 16'(idx * 2 + (c % 2));
            bus1.req_wdata = wd;
            #1;
            will_acc = bus1.req_ready;
            if (will_acc) begin
                acc++;
                if (we) begin
                    model1[idx] = wd;
                    known1[idx] = 1'b1;
                end
                exp_q1.push_back(known1[idx] ? model1[idx] : 16'hxxxx);
            end
            @(negedge clk);
            if (will_acc) chk("l1_valid_next", bus1.resp_valid, 1);
`ifdef MEM_BACK2BACK_EN
            chk("l1_busy_held", busy1, 1);
`endif
            if (bus1.resp_valid === 1'b1) begin
                if (exp_q1.size() == 0) chk("l1_extra_resp", 1, 0);
                else chk("l1_rdata", bus1.resp_rdata, exp_q1.pop_front());
            end
        end
        bus1.req_valid = 1'b0;
        @(negedge clk);
        bus1.resp_ready = 1'b0;
        chk("l1_drained_valid", bus1.resp_valid, 0);
        chk("l1_queue_empty", exp_q1.size(), 0);
`ifdef MEM_BACK2BACK_EN
        chk("l1_accepts", acc, 40);
`else
        chk("l1_accepts", acc, 20);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
